// File: rtl/common_pkg.sv
// Shared types and constants for the register-writeback trace path.
// Frame layout and entry width change when TRACE_PC_EN is defined.
package common_pkg;

  localparam logic [7:0] TRACE_SYNC    = 8'hA5;
  localparam logic [7:0] TRACE_SYNC_PC = 8'hA6;

`ifdef TRACE_PC_EN
  localparam int TRACE_FRAME_BYTES = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  id;
  } trace_entry_t;
`else
  localparam int TRACE_FRAME_BYTES = 6;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  id;
  } trace_entry_t;
`endif

  localparam int TRACE_FRAME_BITS = TRACE_FRAME_BYTES * 8;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser; done pulses in the last STOP cycle.
// Ports: clk, rst (async active-low), data/valid in, done, tx_serial.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       done,
  output logic       tx_serial
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          r_tx, w_tx;
  logic          w_tick;

  assign w_tick    = (r_cnt == LAST);
  assign tx_serial = r_tx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = w_tick ? '0 : r_cnt + 1'b1;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_tx    = r_tx;
    done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        w_tx  = 1'b1;
        if (valid) begin
          w_state = S_START;
          w_shift = data;
          w_tx    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state = S_DATA;
          w_bit   = '0;
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd7) begin
            w_state = S_STOP;
            w_tx    = 1'b1;
          end else begin
            w_bit   = r_bit + 1'b1;
            w_tx    = r_shift[0];
            w_shift = r_shift >> 1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_state = S_IDLE;
          done    = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/reg_trace_tx.sv
// Register-writeback trace: FIFO of commits, framed out over UART TX.
// Ports: clk, rst (async active-low), start, reg_write, write_id,
//   write_data, pc_wb in; tx_serial, busy, overflow, drop_count out.
// Macro TRACE_PC_EN: adds PC to each entry, 10-byte frame, sync 0xA6.
module reg_trace_tx
  import common_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        reg_write,
  input  logic [4:0]  write_id,
  input  logic [31:0] write_data,
  input  logic [31:0] pc_wb,
  output logic        tx_serial,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TRACE_FRAME_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(TRACE_FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_LOAD,
    F_SEND
  } fstate_t;

  trace_entry_t r_mem [DEPTH];
  trace_entry_t w_entry, w_head;
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_empty, w_full;
  logic         w_cap, w_push, w_pop, w_drop;

  fstate_t      r_fstate, w_fstate;
  logic [TRACE_FRAME_BITS-1:0] r_frame, w_head_frame;
  logic [IW-1:0] r_idx;
  logic         r_valid;
  logic         w_done;
  logic         r_ovf;
  logic [7:0]   r_drop;

  assign w_cap = start & reg_write & (write_id != 5'd0);

`ifdef TRACE_PC_EN
  assign w_entry = '{pc: pc_wb, data: write_data, id: write_id};
  assign w_head_frame = {w_head.pc, w_head.data,
                         3'b000, w_head.id, TRACE_SYNC_PC};
`else
  logic w_unused_pc;
  assign w_unused_pc  = ^pc_wb;
  assign w_entry = '{data: write_data, id: write_id};
  assign w_head_frame = {w_head.data,
                         3'b000, w_head.id, TRACE_SYNC};
`endif

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // a pop on the same edge frees the slot for the incoming entry
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fstate <= F_IDLE;
    else      r_fstate <= w_fstate;
  end

  always_comb begin
    w_fstate = r_fstate;
    w_pop    = 1'b0;
    unique case (r_fstate)
      F_IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_fstate = F_LOAD;
        end
      end
      F_LOAD: w_fstate = F_SEND;
      F_SEND: begin
        if (w_done)
          w_fstate = (r_idx == LAST_IDX) ? F_IDLE : F_LOAD;
      end
      default: w_fstate = F_IDLE;
    endcase
  end

  // the current byte always sits in r_frame[7:0]
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_fstate == F_LOAD);
      if (w_pop) begin
        r_frame <= w_head_frame;
        r_idx   <= '0;
      end else if (r_fstate == F_SEND && w_done &&
                   r_idx != LAST_IDX) begin
        r_frame <= r_frame >> 8;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .data     (r_frame[7:0]),
    .valid    (r_valid),
    .done     (w_done),
    .tx_serial(tx_serial)
  );

  assign busy       = ~w_empty | (r_fstate != F_IDLE);
  assign overflow   = r_ovf;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_reg_trace_tx.sv
// Bench for reg_trace_tx: UART decoder feeds a byte scoreboard.
// Build with TRACE_PC_EN defined to also exercise the PC frame.
module tb_reg_trace_tx;

  localparam int CPB = 4;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  write_id = '0;
  logic [31:0] write_data = '0;
  logic [31:0] pc_wb = '0;
  wire         tx_serial;
  wire         busy;
  wire         overflow;
  wire  [7:0]  drop_count;

  reg_trace_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reg_write (reg_write),
    .write_id  (write_id),
    .write_data(write_data),
    .pc_wb     (pc_wb),
    .tx_serial (tx_serial),
    .busy      (busy),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART decoder: 10 bits x CPB samples, each bit must be flat
  logic [10*CPB-1:0] m_sh;
  int m_n = 0;
  bit m_act = 0;
  int m_t = 0;
  always @(negedge clk) begin
    if (!rst) begin
      m_act = 0;
      m_n   = 0;
    end else if (!m_act) begin
      if (tx_serial == 1'b0) begin
        m_act   = 1;
        m_sh[0] = 1'b0;
        m_n     = 1;
        m_t     = cyc;
      end
    end else begin
      m_sh[m_n] = tx_serial;
      m_n++;
      if (m_n == 10 * CPB) begin
        logic [7:0] b;
        for (int k = 0; k < 10; k++)
          for (int s = 1; s < CPB; s++)
            if (m_sh[k*CPB+s] !== m_sh[k*CPB]) m_err++;
        if (m_sh[0] !== 1'b0 || m_sh[9*CPB] !== 1'b1) m_err++;
        for (int j = 0; j < 8; j++) b[j] = m_sh[(j+1)*CPB];
        rx_q.push_back(b);
        rx_t.push_back(m_t);
        m_act = 0;
      end
    end
  end

  task automatic clr();
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic push_frame(input logic [4:0] id,
                            input logic [31:0] d,
                            input logic [31:0] pc);
`ifdef TRACE_PC_EN
    exp_q.push_back(8'hA6);
`else
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back({3'b000, id});
    for (int i = 0; i < 4; i++) exp_q.push_back(d[i*8 +: 8]);
`ifdef TRACE_PC_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(pc[i*8 +: 8]);
`else
    if (pc != pc) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic test_reset();
    int errs = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx_serial !== 1'b1) begin bad++;
      $display("FAIL rst_tx got=%b want=1", tx_serial); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++;
      $display("FAIL rst_ovf got=%b want=0", overflow); end
    total++; if (drop_count !== 8'd0) begin bad++;
      $display("FAIL rst_drop got=%0d want=0", drop_count); end
    rst = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || busy !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++;
      $display("FAIL idle_line bad_cycles=%0d want=0", errs); end
  endtask

  task automatic test_single();
    int n;
    clr();
    @(negedge clk);
    start = 1'b1; reg_write = 1'b1;
    write_id = 5'd5; write_data = 32'hDEADBEEF; pc_wb = '0;
    push_frame(5'd5, 32'hDEADBEEF, 32'h0);
    @(posedge clk); #1 n = cyc;
    @(negedge clk); reg_write = 1'b0;
    total++; if (busy !== 1'b1) begin bad++;
      $display("FAIL single_busy got=%b want=1", busy); end
    for (int k = 0; k < 2000 && rx_q.size() < exp_q.size(); k++)
      @(negedge clk);
    total++; if (rx_q.size() != exp_q.size()) begin bad++;
      $display("FAIL single_len got=%0d want=%0d",
               rx_q.size(), exp_q.size()); end
    else begin
      total++; if (rx_t[0] != n + 3) begin bad++;
        $display("FAIL single_lat got=%0d want=%0d", rx_t[0], n + 3); end
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (rx_q[i] !== exp_q[i]) begin bad++;
          $display("FAIL single_byte%0d got=%h want=%h",
                   i, rx_q[i], exp_q[i]); end
        if (i > 0) begin
          total++; if (rx_t[i] - rx_t[i-1] != 10 * CPB + 2) begin bad++;
            $display("FAIL single_gap%0d got=%0d want=%0d",
                     i, rx_t[i] - rx_t[i-1], 10 * CPB + 2); end
        end
      end
    end
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL single_idle got=%b want=0", busy); end
    total++; if (m_err != 0) begin bad++;
      $display("FAIL single_framing got=%0d want=0", m_err); end
  endtask

  task automatic test_filter();
    int hits = 0;
    clr();
    @(negedge clk);
    start = 1'b1; reg_write = 1'b1;
    write_id = 5'd0; write_data = 32'h12345678;
    @(negedge clk);
    start = 1'b0; write_id = 5'd3;
    @(negedge clk);
    reg_write = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0) hits++;
    end
    start = 1'b1;
    total++; if (hits != 0) begin bad++;
      $display("FAIL filter_busy got=%0d want=0", hits); end
    total++; if (rx_q.size() != 0) begin bad++;
      $display("FAIL filter_rx got=%0d want=0", rx_q.size()); end
  endtask

  task automatic test_overflow();
    int fb = 0;
`ifdef TRACE_PC_EN
    fb = 10;
`else
    fb = 6;
`endif
    clr();
    total++; if (overflow !== 1'b0) begin bad++;
      $display("FAIL ovf_pre got=%b want=0", overflow); end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      reg_write  = 1'b1;
      write_id   = 5'(i);
      write_data = $urandom;
      pc_wb      = $urandom;
      if (i <= DEP + 1) push_frame(5'(i), write_data, pc_wb);
    end
    @(negedge clk);
    reg_write = 1'b0;
    for (int k = 0; k < 20000 && busy; k++) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL ovf_drain busy=%b want=0", busy); end
    repeat (5) @(negedge clk);
    total++; if (drop_count !== 8'd3) begin bad++;
      $display("FAIL ovf_count got=%0d want=3", drop_count); end
    total++; if (overflow !== 1'b1) begin bad++;
      $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (rx_q.size() != exp_q.size()) begin bad++;
      $display("FAIL ovf_len got=%0d want=%0d",
               rx_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (rx_q[i] !== exp_q[i]) begin bad++;
          $display("FAIL ovf_byte%0d got=%h want=%h",
                   i, rx_q[i], exp_q[i]); end
        if (i > 0 && (i % fb) != 0) begin
          total++; if (rx_t[i] - rx_t[i-1] != 10 * CPB + 2) begin bad++;
            $display("FAIL ovf_gap%0d got=%0d want=%0d",
                     i, rx_t[i] - rx_t[i-1], 10 * CPB + 2); end
        end else if (i > 0) begin
          total++; if (rx_t[i] - rx_t[i-1] > 10 * CPB + 3) begin bad++;
            $display("FAIL ovf_fgap%0d got=%0d want<=%0d",
                     i, rx_t[i] - rx_t[i-1], 10 * CPB + 3); end
        end
      end
    end
    total++; if (m_err != 0) begin bad++;
      $display("FAIL ovf_framing got=%0d want=0", m_err); end
  endtask

  task automatic test_reset_mid();
    int k;
    clr();
    @(negedge clk);
    reg_write = 1'b1; write_id = 5'd7; write_data = 32'hCAFEF00D;
    @(negedge clk);
    reg_write = 1'b0;
    for (k = 0; k < 2000 && rx_q.size() < 3; k++) @(negedge clk);
    for (k = 0; k < 2000 && tx_serial !== 1'b0; k++) #1;
    total++; if (tx_serial !== 1'b0) begin bad++;
      $display("FAIL mid_wait tx=%b want=0", tx_serial); end
    #2 rst = 1'b0;
    #1;
    total++; if (tx_serial !== 1'b1) begin bad++;
      $display("FAIL mid_tx got=%b want=1", tx_serial); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin bad++;
      $display("FAIL mid_ovf got=%b/%0d want=0/0", overflow, drop_count); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clr();
    repeat (60) @(negedge clk);
    total++; if (rx_q.size() != 0 || busy !== 1'b0) begin bad++;
      $display("FAIL mid_quiet rx=%0d busy=%b want=0/0", rx_q.size(), busy);
    end
    reg_write = 1'b1; write_id = 5'd9; write_data = 32'h01234567;
    pc_wb = 32'h89ABCDEF;
    push_frame(5'd9, 32'h01234567, 32'h89ABCDEF);
    @(negedge clk);
    reg_write = 1'b0;
    for (k = 0; k < 2000 && rx_q.size() < exp_q.size(); k++)
      @(negedge clk);
    total++; if (rx_q.size() != exp_q.size()) begin bad++;
      $display("FAIL mid_len got=%0d want=%0d", rx_q.size(), exp_q.size());
    end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (rx_q[i] !== exp_q[i]) begin bad++;
          $display("FAIL mid_byte%0d got=%h want=%h",
                   i, rx_q[i], exp_q[i]); end
      end
    end
    total++; if (m_err != 0) begin bad++;
      $display("FAIL mid_framing got=%0d want=0", m_err); end
  endtask

`ifdef TRACE_PC_EN
  task automatic test_pc_frame();
    logic [7:0] ref_b [10];
    ref_b = '{8'hA6, 8'h01, 8'h10, 8'h00, 8'h00,
              8'h00, 8'h24, 8'h00, 8'h00, 8'h00};
    clr();
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    @(negedge clk);
    reg_write = 1'b1; write_id = 5'd1;
    write_data = 32'h10; pc_wb = 32'h24;
    @(negedge clk);
    reg_write = 1'b0;
    for (int k = 0; k < 2000 && rx_q.size() < 10; k++) @(negedge clk);
    total++; if (rx_q.size() != 10) begin bad++;
      $display("FAIL pc_len got=%0d want=10", rx_q.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        total++; if (rx_q[i] !== ref_b[i]) begin bad++;
          $display("FAIL pc_byte%0d got=%h want=%h", i, rx_q[i], ref_b[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_overflow();
    test_reset_mid();
`ifdef TRACE_PC_EN
    test_pc_frame();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
